register_file_param: RTL

Parametrised multi-port register file built from enabled D-flip-flop storage words, generalising the single 32-bit enabled register to a configurable width and depth. Provides one synchronous write port and two read ports, with optional hardwired-zero register, write-to-read forwarding, and selectable combinational or registered reads. It is the CPU register file used by the datapath: operand reads come from the decode stage and the write-back comes from the writeback stage.

---
 rtl/register_file_param.sv | 86 ++++++++
 1 files changed

// File: rtl/register_file_param.sv
// ============================================================================
// register_file_param: parametrised 1-write / 2-read register file with
// optional hardwired zero register, write forwarding and registered reads.
// ============================================================================
`default_nettype none

module register_file_param #(
  parameter int WIDTH        = 32,
  parameter int ADDR_BITS    = 5,
  parameter bit ZERO_REG     = 1'b1,
  parameter bit BYPASS       = 1'b1,
  parameter int READ_LATENCY = 0
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 wrenable,
  input  logic [ADDR_BITS-1:0] writeregister,
  input  logic [WIDTH-1:0]     writedata,
  input  logic [ADDR_BITS-1:0] readregister1,
  input  logic [ADDR_BITS-1:0] readregister2,
  output logic [WIDTH-1:0]     readdata1,
  output logic [WIDTH-1:0]     readdata2
);

  localparam int DEPTH = 2**ADDR_BITS;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic             wr_eff;
  logic             fwd_ok;
  logic [WIDTH-1:0] rdata [2];

  assign wr_eff = wrenable && !(ZERO_REG && (writeregister == '0));
  // Forwarding is suppressed during reset so outputs read the cleared storage.
  assign fwd_ok = BYPASS && wr_eff && !reset;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else if (wr_eff) begin
      mem_q[writeregister] <= writedata;
    end
  end

  for (genvar p = 0; p < 2; p++) begin : g_port
    logic [ADDR_BITS-1:0] addr;
    logic [WIDTH-1:0]     src;

    assign addr = (p == 0) ? readregister1 : readregister2;

    always_comb begin
      src = mem_q[addr];
      if (ZERO_REG && (addr == '0)) begin
        src = '0;
      end else if (fwd_ok && (writeregister == addr)) begin
        src = writedata;
      end
    end

    if (READ_LATENCY == 1) begin : g_reg
      logic [WIDTH-1:0] rd_q;
      logic [WIDTH-1:0] rd_d;

      assign rd_d = src;

      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          rd_q <= '0;
        end else begin
          rd_q <= rd_d;
        end
      end

      assign rdata[p] = rd_q;
    end else begin : g_comb
      assign rdata[p] = src;
    end
  end

  assign readdata1 = rdata[0];
  assign readdata2 = rdata[1];

endmodule

`default_nettype wire
